// File: rtl/core_mem_responder_pkg.sv
// Shared definitions for core_mem_responder: boot FSM encoding, NOP, RV32I load/store funct3 codes
// and the byte-lane helpers used when MEM_BYTE_STORE_EN is defined.
package core_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } boot_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic logic [3:0] store_lanes(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_SB:   store_lanes = 4'b0001 << off;
            F3_SH:   store_lanes = off[1] ? 4'b1100 : 4'b0011;
            default: store_lanes = 4'b1111;
        endcase
    endfunction

    // Replicate narrow store data across the word so any enabled lane sees the right bits.
    function automatic logic [31:0] store_align(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3)
            F3_SB:   store_align = {4{wdata[7:0]}};
            F3_SH:   store_align = {2{wdata[15:0]}};
            default: store_align = wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   load_extract = {{24{b[7]}}, b};
            F3_LBU:  load_extract = {24'h0, b};
            F3_LH:   load_extract = {{16{h[15]}}, h};
            F3_LHU:  load_extract = {16'h0, h};
            default: load_extract = word;
        endcase
    endfunction

endpackage

// File: rtl/core_mem_responder_if.sv
// Core fetch/load/store bus plus program-load byte channel; i_funct3 exists only with MEM_BYTE_STORE_EN.
// slave = responder view, master = core/loader view.
interface core_mem_responder_if;
    logic [11:0] i_pc;
    logic [31:0] o_instr;
    logic [11:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_ld;
    logic        i_sw;
    logic [31:0] o_rdata;
    logic        o_core_rst_n;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        ld_err;
`ifdef MEM_BYTE_STORE_EN
    logic [2:0]  i_funct3;
`endif

    modport slave (
        input  i_pc, i_addr, i_wdata, i_ld, i_sw, ld_start, ld_valid, ld_data, ld_last,
        output o_instr, o_rdata, o_core_rst_n, ld_ready, ld_err
`ifdef MEM_BYTE_STORE_EN
        , input i_funct3
`endif
    );

    modport master (
        output i_pc, i_addr, i_wdata, i_ld, i_sw, ld_start, ld_valid, ld_data, ld_last,
        input  o_instr, o_rdata, o_core_rst_n, ld_ready, ld_err
`ifdef MEM_BYTE_STORE_EN
        , output i_funct3
`endif
    );
endinterface

// File: rtl/core_mem_responder_boot_loader.sv
// Boot FSM + byte-to-word image assembly; imem write issued the edge the 4th/last byte is accepted.
// Backpressure: ld_ready high only in LOAD, one byte per cycle; words past the end are dropped and flag ld_err.
module core_mem_responder_boot_loader
    import core_mem_responder_pkg::*;
#(
    parameter  int IMEM_WORDS = 1024,
    localparam int IW         = $clog2(IMEM_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          ld_err,
    output logic          core_rst_n,
    output logic          run,
    output logic          wr_en,
    output logic [IW-1:0] wr_addr,
    output logic [31:0]   wr_data
);

    boot_state_e  state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [31:0]  asm_q, asm_d;
    logic [IW:0]  wptr_q, wptr_d;
    logic         err_q, err_d;
    logic         crst_q, crst_d;

    logic         accept;
    logic         word_done;
    logic         full;
    logic [31:0]  merged;

    assign ld_ready  = (state_q == ST_LOAD);
    assign accept    = ld_ready && ld_valid;
    assign word_done = accept && ((cnt_q == 2'd3) || ld_last);
    assign full      = (wptr_q == (IW+1)'(IMEM_WORDS));

    // Byte n of a word lands in lane n; lanes above the counter stay zero for short tails.
    always_comb begin
        merged = asm_q;
        merged[{cnt_q, 3'b000} +: 8] = ld_data;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        wptr_d  = wptr_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    asm_d = merged;
                    cnt_d = cnt_q + 2'd1;
                    if (word_done) begin
                        asm_d = '0;
                        cnt_d = '0;
                        if (full) begin
                            err_d = 1'b1;
                        end else begin
                            wr_en  = 1'b1;
                            wptr_d = wptr_q + 1'b1;
                        end
                        if (ld_last) begin
                            wptr_d  = '0;
                            state_d = ST_RELEASE;
                        end
                    end
                end
            end
            ST_RELEASE: state_d = ST_RUN;
            ST_RUN: begin
                if (ld_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    asm_d   = '0;
                    wptr_d  = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
        crst_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            asm_q   <= '0;
            wptr_q  <= '0;
            err_q   <= 1'b0;
            crst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            wptr_q  <= wptr_d;
            err_q   <= err_d;
            crst_q  <= crst_d;
        end
    end

    assign ld_err     = err_q;
    assign core_rst_n = crst_q;
    assign run        = (state_q == ST_RUN);
    assign wr_addr    = wptr_q[IW-1:0];
    assign wr_data    = merged;

endmodule

// File: rtl/core_mem_responder.sv
// Memory responder for the single-cycle core: combinational fetch/load, stores commit at the edge in RUN only.
// Core held in reset while boot_loader fills imem; MEM_BYTE_STORE_EN adds i_funct3 sub-word access.
module core_mem_responder
    import core_mem_responder_pkg::*;
#(
    parameter int IMEM_WORDS = 1024,
    parameter int DMEM_WORDS = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    core_mem_responder_if.slave  bus
);

    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_WORDS);

    logic [31:0]   imem [IMEM_WORDS];
    logic [31:0]   dmem [DMEM_WORDS];

    logic          run;
    logic          core_rst_n;
    logic          img_wr_en;
    logic [IW-1:0] img_wr_addr;
    logic [31:0]   img_wr_data;
    logic [IW-1:0] pc_idx;
    logic [DW-1:0] d_idx;
    logic [31:0]   rd_word;
    logic [31:0]   st_word;
    logic [3:0]    st_lanes;
    logic          st_en;

    core_mem_responder_boot_loader #(.IMEM_WORDS(IMEM_WORDS)) u_boot_loader (
        .clk        (clk),
        .rst_n      (reset),
        .ld_start   (bus.ld_start),
        .ld_valid   (bus.ld_valid),
        .ld_data    (bus.ld_data),
        .ld_last    (bus.ld_last),
        .ld_ready   (bus.ld_ready),
        .ld_err     (bus.ld_err),
        .core_rst_n (core_rst_n),
        .run        (run),
        .wr_en      (img_wr_en),
        .wr_addr    (img_wr_addr),
        .wr_data    (img_wr_data)
    );

    assign bus.o_core_rst_n = core_rst_n;

    always_ff @(posedge clk) begin
        if (img_wr_en) begin
            imem[img_wr_addr] <= img_wr_data;
        end
    end

    assign pc_idx      = bus.i_pc[IW-1:0];
    assign bus.o_instr = run ? imem[pc_idx] : NOP_INSTR;

    assign d_idx   = bus.i_addr[DW+1:2];
    assign rd_word = dmem[d_idx];
    assign st_en   = run && bus.i_sw;

`ifdef MEM_BYTE_STORE_EN
    assign st_lanes    = store_lanes(bus.i_funct3, bus.i_addr[1:0]);
    assign st_word     = store_align(bus.i_funct3, bus.i_wdata);
    assign bus.o_rdata = bus.i_ld ? load_extract(bus.i_funct3, bus.i_addr[1:0], rd_word) : 32'h0;
`else
    assign st_lanes    = 4'b1111;
    assign st_word     = bus.i_wdata;
    assign bus.o_rdata = bus.i_ld ? rd_word : 32'h0;
`endif

    // Read above is pre-edge, so a same-cycle load returns the old word.
    always_ff @(posedge clk) begin
        if (st_en) begin
            for (int b = 0; b < 4; b++) begin
                if (st_lanes[b]) begin
                    dmem[d_idx][b*8 +: 8] <= st_word[b*8 +: 8];
                end
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{bus.i_pc, bus.i_addr};

endmodule

// File: tb/tb_core_mem_responder.sv
// Scoreboard bench for core_mem_responder: expected words queued when images/stores are driven,
// popped as fetches and loads return them. Byte-lane cases only with MEM_BYTE_STORE_EN.
`timescale 1ns/1ps
module tb_core_mem_responder;
    import core_mem_responder_pkg::*;

    localparam int IMEM_WORDS = 1024;
    localparam int DMEM_WORDS = 1024;

    logic clk = 1'b0;
    logic reset;

    core_mem_responder_if bus();

    core_mem_responder #(.IMEM_WORDS(IMEM_WORDS), .DMEM_WORDS(DMEM_WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        if (exp_q.size() == 0) begin
            check_val("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            check_val(tag_q.pop_front(), got, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int guard = 0;
        while (bus.ld_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        if (guard == 20) check_val("ld_ready_timeout", {31'h0, bus.ld_ready}, 32'd1);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.ld_last  = last;
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        send_byte(w[7:0],   1'b0);
        send_byte(w[15:8],  1'b0);
        send_byte(w[23:16], 1'b0);
        send_byte(w[31:24], last);
    endtask

    task automatic wait_run();
        int guard = 0;
        while (bus.o_core_rst_n !== 1'b1 && guard < 10) begin
            tick();
            guard++;
        end
        if (guard == 10) check_val("run_timeout", {31'h0, bus.o_core_rst_n}, 32'd1);
    endtask

    task automatic fetch_pop(input logic [11:0] pc);
        bus.i_pc = pc;
        #1;
        sb_pop(bus.o_instr);
    endtask

    task automatic load_pop(input logic [11:0] addr);
        bus.i_ld   = 1'b1;
        bus.i_addr = addr;
        #1;
        sb_pop(bus.o_rdata);
        bus.i_ld   = 1'b0;
    endtask

    task automatic do_store(input logic [11:0] addr, input logic [31:0] d);
        bus.i_sw    = 1'b1;
        bus.i_addr  = addr;
        bus.i_wdata = d;
        tick();
        bus.i_sw    = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        bus.i_pc     = '0;
        bus.i_addr   = '0;
        bus.i_wdata  = '0;
        bus.i_ld     = 1'b0;
        bus.i_sw     = 1'b0;
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.ld_last  = 1'b0;
`ifdef MEM_BYTE_STORE_EN
        bus.i_funct3 = F3_LW;
`endif
        #12;
        check_val("rst_core_rst_n", {31'h0, bus.o_core_rst_n}, 32'd0);
        check_val("rst_ld_ready",   {31'h0, bus.ld_ready},     32'd1);
        check_val("rst_ld_err",     {31'h0, bus.ld_err},       32'd0);
        check_val("rst_instr_nop",  bus.o_instr,               NOP_INSTR);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Boot image of two words, ld_last on the 8th byte.
        sb_push("img1_w0", 32'h0000_0013);
        sb_push("img1_w1", 32'h0010_0093);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0010_0093, 1'b1);
        check_val("release_core_rst_n", {31'h0, bus.o_core_rst_n}, 32'd0);
        check_val("release_ld_ready",   {31'h0, bus.ld_ready},     32'd0);
        check_val("release_instr_nop",  bus.o_instr,               NOP_INSTR);
        tick();
        check_val("run_core_rst_n", {31'h0, bus.o_core_rst_n}, 32'd1);
        check_val("run_ld_ready",   {31'h0, bus.ld_ready},     32'd0);
        fetch_pop(12'd0);
        fetch_pop(12'd1);

        // Store then load next cycle; idle load returns zero.
        do_store(12'h010, 32'hDEAD_BEEF);
        sb_push("ld_after_sw", 32'hDEAD_BEEF);
        load_pop(12'h010);
        #1;
        check_val("ld_idle_zero", bus.o_rdata, 32'h0);

        // Same-cycle load and store: load sees the old word, store still commits.
        bus.i_ld    = 1'b1;
        bus.i_sw    = 1'b1;
        bus.i_addr  = 12'h010;
        bus.i_wdata = 32'h1234_5678;
        #1;
        check_val("ld_sw_pre_store", bus.o_rdata, 32'hDEAD_BEEF);
        tick();
        bus.i_ld = 1'b0;
        bus.i_sw = 1'b0;
        sb_push("ld_low_bits_ignored", 32'h1234_5678);
        load_pop(12'h013);
        do_store(12'h014, 32'hCAFE_F00D);
        sb_push("ld_neighbour_intact", 32'h1234_5678);
        load_pop(12'h010);
        sb_push("ld_neighbour", 32'hCAFE_F00D);
        load_pop(12'h014);

`ifdef MEM_BYTE_STORE_EN
        bus.i_funct3 = F3_SW;
        do_store(12'h020, 32'h1122_3344);
        bus.i_funct3 = F3_SB;
        do_store(12'h021, 32'h0000_00FF);
        bus.i_funct3 = F3_LW;
        sb_push("sb_merge", 32'h1122_FF44);
        load_pop(12'h020);
        bus.i_funct3 = F3_LB;
        sb_push("lb_sext", 32'hFFFF_FFFF);
        load_pop(12'h021);
        bus.i_funct3 = F3_LBU;
        sb_push("lbu_zext", 32'h0000_00FF);
        load_pop(12'h021);
        bus.i_funct3 = F3_SH;
        do_store(12'h022, 32'h0000_ABCD);
        bus.i_funct3 = F3_LW;
        sb_push("sh_merge", 32'hABCD_FF44);
        load_pop(12'h020);
        bus.i_funct3 = F3_LH;
        sb_push("lh_sext", 32'hFFFF_ABCD);
        load_pop(12'h022);
        bus.i_funct3 = F3_LHU;
        sb_push("lhu_zext", 32'h0000_ABCD);
        load_pop(12'h022);
        bus.i_funct3 = F3_LW;
`endif

        // ld_start with a coincident store: store commits, core drops into reset.
        bus.ld_start = 1'b1;
        bus.i_sw     = 1'b1;
        bus.i_addr   = 12'h020;
        bus.i_wdata  = 32'hA5A5_A5A5;
        tick();
        bus.ld_start = 1'b0;
        bus.i_sw     = 1'b0;
        check_val("start_core_rst_n", {31'h0, bus.o_core_rst_n}, 32'd0);
        check_val("start_ld_ready",   {31'h0, bus.ld_ready},     32'd1);
        check_val("load_instr_nop",   bus.o_instr,               NOP_INSTR);
        do_store(12'h020, 32'h0000_0000);
        sb_push("store_in_load_dropped", 32'hA5A5_A5A5);
        load_pop(12'h020);

        // Short tail: two bytes then ld_last.
        sb_push("short_word", 32'h0000_BBAA);
        sb_push("short_keep_w1", 32'h0010_0093);
        sb_push("pc_wrap", 32'h0000_BBAA);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        wait_run();
        fetch_pop(12'd0);
        fetch_pop(12'd1);
        fetch_pop(12'h400);

        // Overflow: one word more than imem holds; the extra word must not wrap onto imem[0].
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        for (int k = 0; k <= IMEM_WORDS; k++) begin
            if (k < IMEM_WORDS) sb_push($sformatf("ovf_w%0d", k), 32'hA500_0000 | 32'(k));
            send_word(32'hA500_0000 | 32'(k), (k == IMEM_WORDS));
        end
        wait_run();
        check_val("ovf_ld_err", {31'h0, bus.ld_err}, 32'd1);
        for (int k = 0; k < IMEM_WORDS; k++) fetch_pop(12'(k));
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        check_val("start_clears_err", {31'h0, bus.ld_err}, 32'd0);

        // Reset mid-load: partial word discarded, next bytes restart at imem[0].
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        reset = 1'b0;
        #3;
        check_val("midrst_core_rst_n", {31'h0, bus.o_core_rst_n}, 32'd0);
        check_val("midrst_ld_ready",   {31'h0, bus.ld_ready},     32'd1);
        @(negedge clk);
        reset = 1'b1;
        sb_push("midrst_w0", 32'h1122_3344);
        sb_push("midrst_keep_w1", 32'hA500_0001);
        send_word(32'h1122_3344, 1'b1);
        wait_run();
        fetch_pop(12'd0);
        fetch_pop(12'd1);

        check_val("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
